// File: rtl/rcon_gen_if.sv
// rcon_gen_if -- request/response bundle for the AES round-constant generator.
//   master: drives start, mode, dir, adv; observes the constant outputs.
//   slave : the generator itself.
//   start      load/restart request
//   mode[1:0]  key size, sampled on start (00/11=AES-128, 01=AES-192, 10=AES-256)
//   dir        0=forward, 1=reverse, sampled on start
//   adv        step to the next round constant
//   rcon_out   constant byte in the top 8 bits, lower bits zero
//   rcon_valid rcon_out/round_idx hold a valid constant
//   round_idx  current round number (1..N) while valid
//   last       current constant is the final one of the sequence
//   done       sequence finished
interface rcon_gen_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       mode;
  logic             dir;
  logic             adv;
  logic [WIDTH-1:0] rcon_out;
  logic             rcon_valid;
  logic [3:0]       round_idx;
  logic             last;
  logic             done;

  modport master (output start, mode, dir, adv,
                  input  rcon_out, rcon_valid, round_idx, last, done);
  modport slave  (input  start, mode, dir, adv,
                  output rcon_out, rcon_valid, round_idx, last, done);
endinterface

// File: rtl/rcon_gen.sv
// rcon_gen -- AES key-schedule round-constant sequencer.
// Steps through 01,02,04,...,1b,36 (truncated to N rounds for the key size),
// optionally in reverse. Every output comes straight from a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rcon_gen_if.slave (start/mode/dir/adv in, constant/status out)
// Build option: define RCON_REVERSE_EN to honour dir (reverse load and the
// inverse-xtime step). Without it dir is ignored and the sequence is forward.
module rcon_gen #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  rcon_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] rc_q;
  logic [3:0] idx_q;
  logic [3:0] nr_q;     // round count N latched from mode on start
  logic       valid_q;
  logic       last_q;
  logic       done_q;

  function automatic logic [3:0] rounds(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd8;
      2'b10:   return 4'd7;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef RCON_REVERSE_EN
  logic dir_q;

  // Multiply by x^-1 in GF(2^8): undo the reduction when the low bit is set.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? ({1'b0, b[7:1]} ^ 8'h8d) : {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] final_rc(input logic [1:0] m);
    case (m)
      2'b01:   return 8'h80;
      2'b10:   return 8'h40;
      default: return 8'h36;
    endcase
  endfunction
`else
  logic unused_dir;
  assign unused_dir = bus.dir;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rc_q    <= 8'h00;
      idx_q   <= 4'd0;
      nr_q    <= 4'd10;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RCON_REVERSE_EN
      dir_q   <= 1'b0;
`endif
    end else if (bus.start) begin
      // Restart from any state; a coincident adv is dropped. N >= 7, so the
      // first constant is never the last one.
      state   <= RUN;
      nr_q    <= rounds(bus.mode);
      valid_q <= 1'b1;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RCON_REVERSE_EN
      dir_q   <= bus.dir;
      if (bus.dir) begin
        rc_q  <= final_rc(bus.mode);
        idx_q <= rounds(bus.mode);
      end else begin
        rc_q  <= 8'h01;
        idx_q <= 4'd1;
      end
`else
      rc_q    <= 8'h01;
      idx_q   <= 4'd1;
`endif
    end else if (state == RUN && bus.adv) begin
      if (last_q) begin
        state   <= DONE;
        rc_q    <= 8'h00;
        idx_q   <= 4'd0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        done_q  <= 1'b1;
`ifdef RCON_REVERSE_EN
      end else if (dir_q) begin
        rc_q   <= inv_xtime(rc_q);
        idx_q  <= idx_q - 4'd1;
        last_q <= (idx_q == 4'd2);
`endif
      end else begin
        rc_q   <= xtime(rc_q);
        idx_q  <= idx_q + 4'd1;
        last_q <= ((idx_q + 4'd1) == nr_q);
      end
    end
  end

  // rc_q is cleared whenever valid drops, so rcon_out is zero when invalid.
  assign bus.rcon_out   = WIDTH'(rc_q) << (WIDTH - 8);
  assign bus.rcon_valid = valid_q;
  assign bus.round_idx  = idx_q;
  assign bus.last       = last_q;
  assign bus.done       = done_q;

endmodule

// File: doc/rcon_gen.md
RCON_GEN -- requirements
Module: rcon_gen

Interface
REQ-001 Parameter: WIDTH, default 32, output word width; legal range 8..128 (must be ≥8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  load/restart request.
REQ-005 Port: mode  input  2  key size sampled on start: 00=AES-128 (N=10), 01=AES-192 (N=8), 10=AES-256 (N=7), 11=treated as 00.
REQ-006 Port: dir  input  1  sampled on start: 0=forward (round 1..N), 1=reverse (round N..1).
REQ-007 Port: adv  input  1  advance to next round constant.
REQ-008 Port: rcon_out  output  WIDTH  round constant: byte in bits [WIDTH-1:WIDTH-8], all lower bits 0.
REQ-009 Port: rcon_valid  output  1  rcon_out/round_idx hold a valid constant.
REQ-010 Port: round_idx  output  4  current round number (1..N) while valid.
REQ-011 Port: last  output  1  high while valid and current constant is final in sequence.
REQ-012 Port: done  output  1  high while in DONE state.

Function
REQ-013 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 Any state, start=1: enter RUN next edge; latch mode/dir; rcon_valid=1 after that edge (1-cycle latency).
REQ-015 Forward load: byte=0x01, round_idx=1. Reverse load: byte=last constant of mode (0x36 for N=10, 0x80 for N=8, 0x40 for N=7), round_idx=N.
REQ-016 RUN, adv=1, last=0: forward byte <= xtime(byte) = (byte<<1)[7:0] XOR (byte[7] ? 0x1b : 0x00), round_idx+1; reverse byte <= byte[0] ? ((byte>>1) XOR 0x8d) : (byte>>1), round_idx-1.
REQ-017 RUN, adv=1, last=1: enter DONE; rcon_valid=0, rcon_out=0, round_idx=0, done=1.
REQ-018 last = rcon_valid AND (forward ? round_idx==N : round_idx==1).
REQ-019 adv=0 in RUN: all outputs hold.
REQ-020 adv in IDLE or DONE: ignored, no state change.
REQ-021 start and adv same cycle: start wins, adv discarded.
REQ-022 mode/dir changes while RUN: no effect until next start.
REQ-023 rcon_out = 0 whenever rcon_valid=0.
REQ-024 Forward sequence: 01,02,04,08,10,20,40,80,1b,36 truncated to N; reverse is its exact mirror.

Reset
REQ-025 rst_n low: asynchronously enter IDLE; rcon_out=0, rcon_valid=0, round_idx=0, last=0, done=0; latched mode=00, dir=0.
REQ-026 Reset mid-sequence discards progress; after release, first start behaves as REQ-014/015.
REQ-027 rst_n deassertion gives no pulse on any output.

Configuration
REQ-028 Macro RCON_REVERSE_EN defined: dir honoured as specified (reverse load and inverse-xtime step built in).
REQ-029 Macro RCON_REVERSE_EN undefined: dir input present but ignored, always forward; inverse-step logic absent.

Verification
REQ-030 Reset, start with mode=00, dir=0, adv held 1: bytes 01,02,04,08,10,20,40,80,1b,36 on 10 consecutive cycles, round_idx 1..10, last only with 0x36, next cycle done=1, rcon_out=0.
REQ-031 mode=10, dir=1 (RCON_REVERSE_EN defined): start -> 0x40 idx 7; adv x6 -> 20,10,08,04,02,01; last with idx 1; DONE after 7th adv.
REQ-032 WIDTH=32, mode=01, forward, adv toggling 1/0: each value held during adv=0; rcon_out=0x80000000 at idx 8 with last=1.
REQ-033 start asserted together with adv at idx 5: next cycle idx=1, byte 0x01 (restart wins).
REQ-034 rst_n pulsed low mid-cycle at idx 4: outputs zero immediately without clock edge; adv after release ignored until start.
REQ-035 RCON_REVERSE_EN undefined, start with dir=1, mode=00: sequence starts 0x01 idx 1 (forward).
